// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU results, load returns, load issue and hazard query.
interface wb_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            iss_ld;
    logic [4:0]      iss_rd;
    logic [4:0]      q_rs1;
    logic [4:0]      q_rs2;
    logic [4:0]      q_rd;
    logic            q_rs1_use;
    logic            q_rs2_use;
    logic            q_rd_use;
    logic            stall;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
    logic            rd_we;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output iss_ld, iss_rd,
        output q_rs1, q_rs2, q_rd, q_rs1_use, q_rs2_use, q_rd_use,
        input  ld_ready, stall, rd, rd_data, rd_we
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  iss_ld, iss_rd,
        input  q_rs1, q_rs2, q_rd, q_rs1_use, q_rs2_use, q_rd_use,
        output ld_ready, stall, rd, rd_data, rd_we
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered load returns onto the
// regfile write port and tracks outstanding loads for decode hazard stalls.
module wb_arbiter #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned LDQ_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    localparam int unsigned PTR_W = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OUT_W = CNT_W + 6;

    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic            rd_we_q, rd_we_d;
    logic [31:0]     pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [4:0]      mem_rd_q [LDQ_DEPTH];
    logic [4:0]      mem_rd_d [LDQ_DEPTH];
    logic [XLEN-1:0] mem_data_q [LDQ_DEPTH];
    logic [XLEN-1:0] mem_data_d [LDQ_DEPTH];
    // High for the first cycle after reset: stale load returns are dropped
    logic            mask_q, mask_d;

    logic            fifo_empty_c, fifo_full_c, ld_ready_c, stall_c;
    logic            alu_wr_c, pop_c, bypass_c, push_c, ld_acc_c;
    logic [OUT_W-1:0] outstanding_c;

    // Handshake, write-select decode and hazard stall
    always_comb begin
        fifo_empty_c  = (cnt_q == CNT_W'(0));
        fifo_full_c   = (cnt_q == CNT_W'(LDQ_DEPTH));
        ld_ready_c    = !fifo_full_c;
        ld_acc_c      = bus.ld_valid && ld_ready_c && (bus.ld_rd != 5'd0) && !mask_q;
        alu_wr_c      = bus.alu_valid && (bus.alu_rd != 5'd0);
        pop_c         = !alu_wr_c && !fifo_empty_c;
        bypass_c      = !alu_wr_c && fifo_empty_c && ld_acc_c;
        push_c        = ld_acc_c && !bypass_c;
        outstanding_c = OUT_W'(cnt_q);
        for (int i = 0; i < 32; i++) begin
            outstanding_c = outstanding_c + OUT_W'(pend_q[i]);
        end
        stall_c = (bus.q_rs1_use && pend_q[bus.q_rs1])
                | (bus.q_rs2_use && pend_q[bus.q_rs2])
                | (bus.q_rd_use  && pend_q[bus.q_rd])
                | (bus.iss_ld && (outstanding_c >= OUT_W'(LDQ_DEPTH)));
    end

    // Next-state: write port, FIFO and scoreboard
    always_comb begin
        rd_d       = rd_q;
        rd_data_d  = rd_data_q;
        rd_we_d    = 1'b0;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        head_d     = head_q;
        tail_d     = tail_q;
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        mask_d     = 1'b0;

        if (alu_wr_c) begin
            rd_d      = bus.alu_rd;
            rd_data_d = bus.alu_data;
            rd_we_d   = 1'b1;
        end else if (pop_c) begin
            rd_d      = mem_rd_q[head_q];
            rd_data_d = mem_data_q[head_q];
            rd_we_d   = 1'b1;
            pend_d[mem_rd_q[head_q]] = 1'b0;
            head_d    = head_q + PTR_W'(1);
        end else if (bypass_c) begin
            rd_d      = bus.ld_rd;
            rd_data_d = bus.ld_data;
            rd_we_d   = 1'b1;
            pend_d[bus.ld_rd] = 1'b0;
        end

        if (push_c) begin
            mem_rd_d[tail_q]   = bus.ld_rd;
            mem_data_d[tail_q] = bus.ld_data;
            tail_d             = tail_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);

        // A new issue to the same register wins over a same-cycle clear
        if (bus.iss_ld && !stall_c && (bus.iss_rd != 5'd0)) begin
            pend_d[bus.iss_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q      <= 5'd0;
            rd_data_q <= XLEN'(0);
            rd_we_q   <= 1'b0;
            pend_q    <= 32'd0;
            cnt_q     <= CNT_W'(0);
            head_q    <= PTR_W'(0);
            tail_q    <= PTR_W'(0);
            mask_q    <= 1'b1;
            for (int i = 0; i < int'(LDQ_DEPTH); i++) begin
                mem_rd_q[i]   <= 5'd0;
                mem_data_q[i] <= XLEN'(0);
            end
        end else begin
            rd_q       <= rd_d;
            rd_data_q  <= rd_data_d;
            rd_we_q    <= rd_we_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            mask_q     <= mask_d;
            mem_rd_q   <= mem_rd_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign bus.rd       = rd_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_we    = rd_we_q;
    assign bus.ld_ready = ld_ready_c;
    assign bus.stall    = stall_c;

    // ALU must never target a register with an outstanding load
    ap_alu_no_pend: assert property (@(posedge clk) disable iff (rst)
        alu_wr_c |-> !pend_q[bus.alu_rd]);

    // Every load return must match an outstanding load
    ap_ld_pend: assert property (@(posedge clk) disable iff (rst || mask_q)
        (bus.ld_valid && ld_ready_c && (bus.ld_rd != 5'd0)) |-> pend_q[bus.ld_rd]);
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: write priority, FIFO, scoreboard and reset.
module tb_wb_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    wb_arbiter_if #(.XLEN(32)) bus ();

    wb_arbiter #(.XLEN(32), .LDQ_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
        bus.ld_valid  = 1'b0; bus.ld_rd  = 5'd0; bus.ld_data  = 32'd0;
        bus.iss_ld    = 1'b0; bus.iss_rd = 5'd0;
        bus.q_rs1 = 5'd0; bus.q_rs2 = 5'd0; bus.q_rd = 5'd0;
        bus.q_rs1_use = 1'b0; bus.q_rs2_use = 1'b0; bus.q_rd_use = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [4:0] r, input logic [31:0] d);
        bus.alu_valid = 1'b1; bus.alu_rd = r; bus.alu_data = d;
    endtask

    task automatic ld(input logic [4:0] r, input logic [31:0] d);
        bus.ld_valid = 1'b1; bus.ld_rd = r; bus.ld_data = d;
    endtask

    task automatic iss(input logic [4:0] r);
        bus.iss_ld = 1'b1; bus.iss_rd = r;
    endtask

    task automatic wr(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
        chk({tag, ".we"}, 64'(bus.rd_we), 64'(we));
        if (we) begin
            chk({tag, ".rd"},   64'(bus.rd),      64'(r));
            chk({tag, ".data"}, 64'(bus.rd_data), 64'(d));
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        idle();

        // 1: reset then idle
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("t1.we",    64'(bus.rd_we),    64'd0);
        chk("t1.rd",    64'(bus.rd),       64'd0);
        chk("t1.data",  64'(bus.rd_data),  64'd0);
        chk("t1.ready", 64'(bus.ld_ready), 64'd1);
        chk("t1.stall", 64'(bus.stall),    64'd0);

        // 2: single ALU write
        alu(5'd5, 32'hDEADBEEF);
        tick(); idle();
        wr("t2.w", 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        wr("t2.idle", 1'b0, 5'd0, 32'd0);

        // 3: load hazard then direct (bypass) load write
        iss(5'd7); #1;
        chk("t3.iss_stall", 64'(bus.stall), 64'd0);
        tick(); idle();
        bus.q_rs1 = 5'd7; bus.q_rs1_use = 1'b1; #1;
        chk("t3.raw_stall", 64'(bus.stall), 64'd1);
        ld(5'd7, 32'h1234);
        tick(); bus.ld_valid = 1'b0;
        wr("t3.w", 1'b1, 5'd7, 32'h1234);
        chk("t3.stall_clr", 64'(bus.stall), 64'd0);
        idle();

        // 4: ALU and load collide, load goes through FIFO
        iss(5'd4);
        tick(); idle();
        alu(5'd3, 32'hA); ld(5'd4, 32'hB);
        tick(); idle();
        wr("t4.alu", 1'b1, 5'd3, 32'hA);
        tick();
        wr("t4.ld", 1'b1, 5'd4, 32'hB);
        tick();
        wr("t4.idle", 1'b0, 5'd0, 32'd0);

        // 5: two outstanding loads, ALU burst, FIFO fill and drain
        iss(5'd8);
        tick();
        iss(5'd9); #1;
        chk("t5.stall1", 64'(bus.stall), 64'd0);
        tick();
        iss(5'd10); #1;
        chk("t5.stall2", 64'(bus.stall), 64'd1);
        idle();
        alu(5'd1, 32'h11); ld(5'd8, 32'h88); #1;
        chk("t5.ready0", 64'(bus.ld_ready), 64'd1);
        tick(); idle();
        alu(5'd2, 32'h22); ld(5'd9, 32'h99); #1;
        chk("t5.ready1", 64'(bus.ld_ready), 64'd1);
        wr("t5.w1", 1'b1, 5'd1, 32'h11);
        tick(); idle();
        alu(5'd3, 32'h33); #1;
        chk("t5.ready_full", 64'(bus.ld_ready), 64'd0);
        wr("t5.w2", 1'b1, 5'd2, 32'h22);
        tick(); idle(); #1;
        chk("t5.ready_full2", 64'(bus.ld_ready), 64'd0);
        wr("t5.w3", 1'b1, 5'd3, 32'h33);
        tick();
        chk("t5.ready_pop", 64'(bus.ld_ready), 64'd1);
        wr("t5.w8", 1'b1, 5'd8, 32'h88);
        tick();
        wr("t5.w9", 1'b1, 5'd9, 32'h99);
        iss(5'd10); #1;
        chk("t5.stall_done", 64'(bus.stall), 64'd0);
        bus.iss_ld = 1'b0;
        tick();
        wr("t5.idle", 1'b0, 5'd0, 32'd0);

        // 6: x0 issue and return, then reset with one FIFO entry
        iss(5'd12);
        tick();
        iss(5'd0); #1;
        chk("t6.iss0_stall", 64'(bus.stall), 64'd0);
        tick();
        iss(5'd13); #1;
        chk("t6.iss0_nopend", 64'(bus.stall), 64'd0);
        idle();
        ld(5'd0, 32'h5555); #1;
        chk("t6.ld0_ready", 64'(bus.ld_ready), 64'd1);
        tick(); idle();
        wr("t6.ld0_nowr", 1'b0, 5'd0, 32'd0);
        alu(5'd1, 32'h77); ld(5'd12, 32'hCC);
        tick(); idle();
        wr("t6.alu", 1'b1, 5'd1, 32'h77);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr("t6.rst_we", 1'b0, 5'd0, 32'd0);
        ld(5'd12, 32'hEE);
        bus.q_rs1 = 5'd12; bus.q_rs1_use = 1'b1; #1;
        chk("t6.rst_pend", 64'(bus.stall), 64'd0);
        chk("t6.rst_ready", 64'(bus.ld_ready), 64'd1);
        tick(); idle();
        wr("t6.rst_drop", 1'b0, 5'd0, 32'd0);
        tick();
        wr("t6.rst_empty", 1'b0, 5'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
